carryskip_addsub_seq: RTL
=========================

CARRYSKIP_ADDSUB_SEQ -- requirements
Module: carryskip_addsub_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: BLOCK, 4, carry-skip block width; WIDTH SHALL be an integer multiple of BLOCK; NB = WIDTH/BLOCK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present on in1/in2/carry_in/sub.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in1  input  WIDTH  first operand.
REQ-008 in2  input  WIDTH  second operand.
REQ-009 carry_in  input  1  carry-in (add) or borrow-in (sub).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 carry_final  output  1  carry out of MSB block.
REQ-015 skip_mask  output  NB  bit k = 1 when block k's carry was taken via the skip path (all bits propagate).
REQ-016 overflow  output  1  signed overflow; present only with CSA_OVERFLOW_EN.

Function
REQ-017 FSM states: IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 IDLE: on in_valid & in_ready at an edge, latch A = in1; B = sub ? ~in2 : in2; c0 = sub ? ~carry_in : carry_in; block index = 0; go to CALC.
REQ-019 CALC: one BLOCK-bit slice per cycle, LSB block first; slice sum = A_k + B_k + c_k written into sum[k]; P_k = &(A_k ^ B_k); c_(k+1) = P_k ? c_k : ripple carry out of slice; skip_mask[k] = P_k.
REQ-020 After the edge that computes block NB-1, carry_final = c_NB; state goes to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NB edges after the accepting edge (2 for defaults).
REQ-022 DONE: sum, carry_final, skip_mask (and overflow) held stable until out_valid & out_ready at an edge; then go to IDLE.
REQ-023 No accept in CALC or DONE; in1/in2/carry_in/sub changes outside the accepting edge SHALL have no effect.
REQ-024 sub = 1: sum = in1 - in2 - carry_in mod 2^WIDTH; carry_final = 1 means no borrow.
REQ-025 sub = 0: {carry_final, sum} = in1 + in2 + carry_in.
REQ-026 Earliest next accept: edge after the result-accepting edge (in_ready rises combinationally from IDLE).
REQ-027 Result registers not yet written in the current operation SHALL hold their previous values.

Reset
REQ-028 rst asserted at any time, including mid-CALC or DONE, SHALL immediately force IDLE, sum = 0, carry_final = 0, skip_mask = 0, overflow = 0, out_valid = 0, in_ready = 1; any in-flight operation is discarded.
REQ-029 First accept is possible at the first rising edge after rst deasserts.

Configuration
REQ-030 Macro CSA_OVERFLOW_EN defined: port overflow exists, = carry into MSB XOR c_NB, updated with carry_final, held in DONE.
REQ-031 CSA_OVERFLOW_EN undefined: no overflow port, no related logic; all other behaviour identical.

Verification
REQ-032 Add in1=8'hAC, in2=8'h31, carry_in=0 -> after 2 edges out_valid=1, sum=8'hDD, carry_final=0, skip_mask=2'b00.
REQ-033 Add in1=8'hB1, in2=8'h3A, carry_in=1 -> sum=8'hEC, carry_final=0; add 8'h0F+8'hF0, carry_in=1 -> sum=8'h00, carry_final=1, skip_mask=2'b11.
REQ-034 Sub in1=8'h50, in2=8'h20, carry_in=0 -> sum=8'h30, carry_final=1, skip_mask=2'b01; sub 8'h20-8'h50 -> sum=8'hD0, carry_final=0.
REQ-035 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 rst pulsed one cycle after accept (mid-CALC) -> outputs 0, in_ready=1 immediately, no out_valid follows.
REQ-037 With CSA_OVERFLOW_EN: add 8'h7F+8'h01, carry_in=0 -> sum=8'h80, overflow=1, carry_final=0.

Source files
------------

// File: rtl/carryskip_addsub_seq.sv
// Sequential carry-skip adder/subtractor: one BLOCK-bit slice is resolved per clock, LSB slice first.
// Define CSA_OVERFLOW_EN to add the signed-overflow output.
module carryskip_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in1,
  input  logic [WIDTH-1:0]         in2,
  input  logic                     carry_in,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     carry_final,
  output logic [WIDTH/BLOCK-1:0]   skip_mask
`ifdef CSA_OVERFLOW_EN
  ,
  output logic                     overflow
`endif
);

  localparam int NB = WIDTH / BLOCK;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [NB-1:0]    skip_q, skip_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [BLOCK-1:0] aSlice;
  logic [BLOCK-1:0] bSlice;
  logic [BLOCK:0]   sliceSum;
  logic             propagate;
  logic             cNext;

`ifdef CSA_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic cIntoMsb;
`endif

  // Subtraction is folded into the add path at accept time, so this slice adder never sees sub.
  always_comb begin
    aSlice    = a_q[idx_q*BLOCK +: BLOCK];
    bSlice    = b_q[idx_q*BLOCK +: BLOCK];
    sliceSum  = {1'b0, aSlice} + {1'b0, bSlice} + {{BLOCK{1'b0}}, c_q};
    propagate = &(aSlice ^ bSlice);
    cNext     = propagate ? c_q : sliceSum[BLOCK];
  end

`ifdef CSA_OVERFLOW_EN
  assign cIntoMsb = aSlice[BLOCK-1] ^ bSlice[BLOCK-1] ^ sliceSum[BLOCK-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    skip_d  = skip_q;
`ifdef CSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          c_d     = sub ? ~carry_in : carry_in;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Only the current slice is written; untouched slices keep the previous result.
        sum_d[idx_q*BLOCK +: BLOCK] = sliceSum[BLOCK-1:0];
        skip_d[idx_q]               = propagate;
        c_d                         = cNext;
        if (idx_q == IW'(NB - 1)) begin
          carry_d = cNext;
`ifdef CSA_OVERFLOW_EN
          ovf_d   = cIntoMsb ^ cNext;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      skip_q  <= '0;
`ifdef CSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      skip_q  <= skip_d;
`ifdef CSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign carry_final = carry_q;
  assign skip_mask   = skip_q;
`ifdef CSA_OVERFLOW_EN
  assign overflow    = ovf_q;
`endif

endmodule
